// File: rtl/dino_pkg.sv
// dino_pkg: definitions shared by the Dino game display pipeline.
//   - SCREEN_W / SCREEN_H : visible raster size in pixels.
//   - rgb12_t             : 12-bit colour, bbbb_gggg_rrrr.
//   - RGB_TRANSPARENT     : colour value the obstacle layer treats as "no pixel".
//   - obst_state_t        : flight state of a scrolling obstacle.
package dino_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t RGB_TRANSPARENT = 12'h000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } obst_state_t;

endpackage

// File: rtl/cactus_small_if.sv
// cactus_small_if: bundle between the obstacle layer and one cactus sprite.
//   step     : one-cycle move strobe (game-speed tick)
//   start    : launch request
//   col_addr : scan x coordinate (0..639)
//   row_addr : scan y coordinate (0..479)
//   dout     : registered pixel colour, 12'h000 = transparent
//   finish   : 1 = idle / off-screen, 0 = obstacle in flight
// master = obstacle layer side, slave = sprite side.
interface cactus_small_if;
  import dino_pkg::*;

  logic       step;
  logic       start;
  logic [9:0] col_addr;
  logic [8:0] row_addr;
  rgb12_t     dout;
  logic       finish;

  modport master (
    output step, start, col_addr, row_addr,
    input  dout, finish
  );

  modport slave (
    input  step, start, col_addr, row_addr,
    output dout, finish
  );

endinterface

// File: rtl/cactus_small_rom.sv
// cactus_small_rom: combinational 16x32 one-bit bitmap of the small cactus.
//   dy     : row within the sprite (0..31)
//   dx     : column within the sprite (0..15)
//   opaque : 1 when the pixel belongs to the cactus
// Shape: trunk in columns 6..9 on every row; left arm in columns 1..2 over
// rows 8..19, bridged to the trunk (columns 3..5) on rows 18..19; right arm in
// columns 13..14 over rows 4..15, bridged to the trunk (columns 10..12) on
// rows 14..15.
module cactus_small_rom (
  input  logic [4:0] dy,
  input  logic [3:0] dx,
  output logic       opaque
);

  logic trunk;
  logic left_arm;
  logic left_join;
  logic right_arm;
  logic right_join;

  always_comb begin
    trunk      = (dx >= 4'd6) && (dx <= 4'd9);
    left_arm   = ((dx == 4'd1) || (dx == 4'd2)) && (dy >= 5'd8) && (dy <= 5'd19);
    left_join  = (dx >= 4'd3) && (dx <= 4'd5) && ((dy == 5'd18) || (dy == 5'd19));
    right_arm  = ((dx == 4'd13) || (dx == 4'd14)) && (dy >= 5'd4) && (dy <= 5'd15);
    right_join = (dx >= 4'd10) && (dx <= 4'd12) && ((dy == 5'd14) || (dy == 5'd15));
    opaque     = trunk || left_arm || left_join || right_arm || right_join;
  end

endmodule

// File: rtl/cactus_small.sv
// cactus_small: small-cactus obstacle sprite. On start it places the sprite's
// left edge at the right screen edge and moves it left by SPEED pixels per
// step strobe until it has completely left the screen, then returns to idle.
// Colour queries from the scan addresses are answered one clock later.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cactus_small_if.slave (step, start, col_addr, row_addr -> dout, finish)
// Optional build macro CACTUS_S_BBOX_EN: while in flight, paints the sprite
// bounding-box perimeter red (12'h00F) to make the hit box visible.
module cactus_small
  import dino_pkg::*;
#(
  parameter int     SCREEN_W     = 640,
  parameter int     SPRITE_W     = 16,
  parameter int     SPRITE_H     = 32,
  parameter int     Y_TOP        = 400,
  parameter int     SPEED        = 1,
  parameter rgb12_t CACTUS_COLOR = 12'h353
) (
  input  logic           clk,
  input  logic           rst_n,
  cactus_small_if.slave  bus
);

  localparam logic signed [10:0] X_LAUNCH = 11'(SCREEN_W);
  localparam logic signed [10:0] X_GONE   = 11'(-SPRITE_W);
  localparam logic signed [10:0] SPEED_S  = 11'(SPEED);
  localparam logic signed [10:0] SPR_W    = 11'(SPRITE_W);
  localparam logic signed [9:0]  SPR_H    = 10'(SPRITE_H);
  localparam logic signed [9:0]  Y_TOP_S  = 10'(Y_TOP);
  localparam logic [9:0]         VIS_W    = 10'(SCREEN_W);
  localparam logic [8:0]         VIS_H    = 9'(dino_pkg::SCREEN_H);
`ifdef CACTUS_S_BBOX_EN
  localparam logic signed [10:0] SPR_W_M1 = 11'(SPRITE_W - 1);
  localparam logic signed [9:0]  SPR_H_M1 = 10'(SPRITE_H - 1);
  localparam rgb12_t             BBOX_RED = 12'h00F;
`endif

  obst_state_t       state_q, state_d;
  logic signed [10:0] x_q, x_d;
  logic signed [10:0] x_step;
  rgb12_t            dout_q, dout_d;

  logic signed [10:0] dx;
  logic signed [9:0]  dy;
  logic               in_view;
  logic               hit;
  logic               opaque;
  logic               finish_o;

  // State register: x is the signed left edge, so partially off-screen
  // positions (negative x) fall out of the hit test without extra clipping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= X_GONE;
      dout_q  <= RGB_TRANSPARENT;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      dout_q  <= dout_d;
    end
  end

  // Next state: a launch has priority over a coincident step while idle, and
  // start is ignored once in flight. x freezes at its final value on landing.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    x_step  = x_q - SPEED_S;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          x_d     = X_LAUNCH;
        end
      end
      ST_RUN: begin
        if (bus.step) begin
          x_d = x_step;
          if (x_step <= X_GONE) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  cactus_small_rom u_rom (
    .dy     (dy[4:0]),
    .dx     (dx[3:0]),
    .opaque (opaque)
  );

  // Outputs: hit test against the current x, colour registered next edge.
  // Addresses outside the visible raster never hit, so a sprite sitting past
  // the right edge stays hidden even though col_addr could encode it.
  always_comb begin
    finish_o = (state_q == ST_IDLE);
    dx       = $signed({1'b0, bus.col_addr}) - x_q;
    dy       = $signed({1'b0, bus.row_addr}) - Y_TOP_S;
    in_view  = (bus.col_addr < VIS_W) && (bus.row_addr < VIS_H);
    hit      = !finish_o && in_view &&
               !dx[10] && (dx < SPR_W) &&
               !dy[9]  && (dy < SPR_H);
    dout_d   = RGB_TRANSPARENT;
`ifdef CACTUS_S_BBOX_EN
    if (hit && ((dx == 11'sd0) || (dx == SPR_W_M1) ||
                (dy == 10'sd0) || (dy == SPR_H_M1))) begin
      dout_d = BBOX_RED;
    end else if (hit && opaque) begin
      dout_d = CACTUS_COLOR;
    end
`else
    if (hit && opaque) begin
      dout_d = CACTUS_COLOR;
    end
`endif
  end

  assign bus.dout   = dout_q;
  assign bus.finish = finish_o;

endmodule

// File: tb/tb_cactus_small.sv
// tb_cactus_small: directed bench for cactus_small (default build).
// Inputs change just after the falling edge; outputs are sampled on the
// falling edge, half a cycle after the rising edge that updated them.
module tb_cactus_small;
  import dino_pkg::*;

  localparam logic [31:0] CC = 32'h353;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  cactus_small_if bus ();

  cactus_small dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_steps(input int n);
    for (int i = 0; i < n; i++) begin
      bus.step = 1'b1;
      @(negedge clk);
    end
    bus.step = 1'b0;
  endtask

  task automatic query(input int c, input int r);
    bus.col_addr = 10'(c);
    bus.row_addr = 9'(r);
    bus.step     = 1'b0;
    bus.start    = 1'b0;
    @(negedge clk);
  endtask

  task automatic launch();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.step     = 1'b0;
    bus.start    = 1'b0;
    bus.col_addr = 10'd0;
    bus.row_addr = 9'd0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_finish", 32'(bus.finish), 32'd1);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    rst_n = 1'b1;
    query(100, 410);
    chk("idle_dout", 32'(bus.dout), 32'd0);
    chk("idle_finish", 32'(bus.finish), 32'd1);

    // launch: x = 640, sprite entirely past the visible edge
    launch();
    chk("launch_finish", 32'(bus.finish), 32'd0);
    query(646, 400);
    chk("clip_646", 32'(bus.dout), 32'd0);
    query(639, 400);
    chk("clip_639", 32'(bus.dout), 32'd0);

    // x = 600
    do_steps(40);
    query(606, 410);
    chk("trunk_606", 32'(bus.dout), CC);
    query(603, 410);
    chk("gap_603", 32'(bus.dout), 32'd0);
    query(600, 400);
    chk("corner_600", 32'(bus.dout), 32'd0);
    query(602, 410);
    chk("larm_602", 32'(bus.dout), CC);
    query(613, 405);
    chk("rarm_613", 32'(bus.dout), CC);
    query(604, 418);
    chk("ljoin_604", 32'(bus.dout), CC);
    query(604, 417);
    chk("above_join", 32'(bus.dout), 32'd0);
    query(606, 432);
    chk("below_spr", 32'(bus.dout), 32'd0);
    query(606, 399);
    chk("above_spr", 32'(bus.dout), 32'd0);

    // x = -10: only the right portion is visible
    do_steps(610);
    query(3, 405);
    chk("lclip_rarm", 32'(bus.dout), CC);
    query(0, 410);
    chk("lclip_gap", 32'(bus.dout), 32'd0);
    query(0, 414);
    chk("lclip_rjoin", 32'(bus.dout), CC);

    // 655 steps: still in flight; step 656 lands
    do_steps(5);
    chk("finish_655", 32'(bus.finish), 32'd0);
    do_steps(1);
    chk("finish_656", 32'(bus.finish), 32'd1);
    query(0, 414);
    chk("after_land", 32'(bus.dout), 32'd0);
    do_steps(3);
    chk("idle_steps", 32'(bus.finish), 32'd1);

    // start and step together while idle: load wins -> x = 640, then 630
    bus.start = 1'b1;
    bus.step  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.step  = 1'b0;
    chk("relaunch_fin", 32'(bus.finish), 32'd0);
    do_steps(10);
    query(635, 410);
    chk("x630_gap", 32'(bus.dout), 32'd0);
    query(636, 410);
    chk("x630_trunk", 32'(bus.dout), CC);

    // x = 300, start mid-flight is ignored
    do_steps(330);
    query(306, 410);
    chk("x300_trunk", 32'(bus.dout), CC);
    launch();
    chk("mid_start_fin", 32'(bus.finish), 32'd0);
    query(305, 410);
    chk("mid_start_305", 32'(bus.dout), 32'd0);
    query(306, 410);
    chk("mid_start_306", 32'(bus.dout), CC);

    // asynchronous reset mid-flight
    #2 rst_n = 1'b0;
    #1;
    chk("arst_finish", 32'(bus.finish), 32'd1);
    chk("arst_dout", 32'(bus.dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    query(306, 410);
    chk("post_rst_dout", 32'(bus.dout), 32'd0);
    chk("post_rst_fin", 32'(bus.finish), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cactus_small.md
# cactus_small

Small-cactus obstacle sprite for the Dino game display pipeline. When triggered, it scrolls one cactus bitmap from the right screen edge to the left, one column step per move strobe. It answers per-pixel colour queries from the VGA scan addresses and reports when the obstacle has fully left the screen. It sits under the obstacle layer, which launches obstacles and merges their colour outputs.

## Interface
Parameters:
- SCREEN_W, 640: visible width; the launch x position.
- SPRITE_W, 16: sprite width in pixels.
- SPRITE_H, 32: sprite height in pixels.
- Y_TOP, 400: screen row of the sprite's top line.
- SPEED, 1: pixels moved per step.
- CACTUS_COLOR, 12'h353: colour for opaque pixels, bbbb_gggg_rrrr.

Ports:
- clk, input, 1: single system clock; all state on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- step, input, 1: one-cycle move strobe (game-speed tick).
- start, input, 1: launch request, sampled each clk.
- col_addr, input, 10: scan x coordinate, 0..639.
- row_addr, input, 9: scan y coordinate, 0..479.
- dout, output, 12: pixel colour, bbbb_gggg_rrrr; 12'h000 means transparent.
- finish, output, 1: 1 = idle/off-screen, 0 = obstacle in flight.

## Operation
- State: signed 11-bit x (sprite left edge) and the finish flag. Two states: IDLE (finish=1) and RUN (finish=0).
- IDLE -> RUN: start=1 loads x=SCREEN_W and clears finish. A start in RUN is ignored; no restart.
- RUN: each step decrements x by SPEED.
- RUN -> IDLE: on the step where the new x ≤ −SPRITE_W, set finish=1. Freeze x at that value.
- start and step in the same cycle while IDLE: the load wins; that step is ignored.
- Hit test, combinational on the addresses:
  - dx = col_addr − x, signed 11-bit.
  - dy = row_addr − Y_TOP.
  - hit when 0 ≤ dx < SPRITE_W and 0 ≤ dy < SPRITE_H and finish=0.
- On hit, look up the 1-bit bitmap at (dy, dx). dout = CACTUS_COLOR if the bit is opaque, else 12'h000. No hit gives 12'h000.
- Partially off-screen sprites clip naturally: negative x shows its right portion, x>SCREEN_W−SPRITE_W shows its left portion.
- Bitmap shape is a cactus: central trunk in columns 6..9 over all rows, plus two arms.
  - Left arm: columns 1..2, rows 8..19, joined to the trunk at rows 18..19.
  - Right arm: columns 13..14, rows 4..15, joined to the trunk at rows 14..15.
  - Every other bit is transparent.

## Timing
- Reset: x=−SPRITE_W, finish=1, dout=12'h000.
- start to finish=0: 1 clk.
- dout is registered, valid 1 clk after col_addr/row_addr are presented. It uses the x value at the address-sample edge.
- Flight length at SPEED=1: 656 steps from launch until finish=1.
- Reset mid-flight: immediate return to IDLE, with dout=0 asynchronously.

## Configuration
- CACTUS_S_BBOX_EN: when defined, pixels on the sprite bounding-box perimeter output 12'h00F (red) while in flight, for hit-box debugging. Without it, only bitmap pixels are drawn.

## Structure
- Shared package `dino_pkg`:
  - Screen constants: SCREEN_W=640, SCREEN_H=480.
  - Colour typedef: logic [11:0] rgb12_t.
  - Transparent constant 12'h000.
- One sub-module, `cactus_small_rom`: combinational bitmap lookup (dy 5-bit, dx 4-bit → 1-bit opaque).

## Test plan
- Reset, then query (100, 410) -> dout=0, finish=1.
- start pulse -> next clk finish=0. Query col=646 (dx=6), row=400 -> dout=0 because the sprite is clipped off-screen.
- start, then 40 steps (x=600). Query (606, 410) -> CACTUS_COLOR one clk later. Query (603, 410) -> 0 (transparent gap).
- start, then 656 steps -> finish rises on step 656 and not before; all queries afterward give 0.
- Mid-flight start with x=300 -> x unchanged, finish stays 0.
- Assert rst_n low at x=300 -> finish=1 and dout=0 without waiting for a clock edge.
